// File: rtl/temp_monitor.sv
// temp_monitor
//   Three-channel over/under temperature monitor for ADT7320 readings.
//   Each channel has its own NORMAL/HIGH/LOW state machine with a
//   debounce counter, so an alarm is entered or left only after DEBOUNCE
//   consecutive qualifying samples. Leaving an alarm uses the limit moved
//   inward by the hysteresis value.
//
//   Optional feature: define TEMP_MONITOR_MINMAX_EN to add per-channel
//   running maximum/minimum registers and the tmax0..2 / tmin0..2 ports.
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous reset, active low
//   sample               one-cycle strobe, result0..2 valid in that cycle
//   result0..2   [15:0]  raw ADT7320 words, temperature in bits [15:3]
//   t_hi, t_lo   [12:0]  signed high/low limits, 1/16 degC per LSB
//   hyst         [3:0]   hysteresis in LSBs, applied on alarm exit
//   clear                one-cycle strobe, clears status (and min/max)
//   alarm        [2:0]   channel is in HIGH or LOW
//   over         [2:0]   channel is in HIGH
//   irq                  one-cycle pulse after any channel enters an alarm
//   status       [2:0]   sticky "alarm has occurred" per channel
//   tmax0..2, tmin0..2   running extremes (TEMP_MONITOR_MINMAX_EN only)
module temp_monitor #(
  parameter int DEBOUNCE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample,
  input  logic [15:0]        result0,
  input  logic [15:0]        result1,
  input  logic [15:0]        result2,
  input  logic signed [12:0] t_hi,
  input  logic signed [12:0] t_lo,
  input  logic [3:0]         hyst,
  input  logic               clear,
  output logic [2:0]         alarm,
  output logic [2:0]         over,
  output logic               irq,
  output logic [2:0]         status
`ifdef TEMP_MONITOR_MINMAX_EN
  ,
  output logic signed [12:0] tmax0,
  output logic signed [12:0] tmax1,
  output logic signed [12:0] tmax2,
  output logic signed [12:0] tmin0,
  output logic signed [12:0] tmin1,
  output logic signed [12:0] tmin2
`endif
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2
  } state_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic               armed;
  logic               sample_ok;
  logic signed [12:0] temp      [3];
  logic signed [13:0] temp_x    [3];
  logic signed [13:0] hyst_x;
  logic signed [13:0] hi_exit;
  logic signed [13:0] lo_exit;
  state_t             state     [3];
  state_t             state_nxt [3];
  logic [3:0]         cnt       [3];
  logic [3:0]         cnt_nxt   [3];
  logic               dir_lo    [3];
  logic               dir_lo_nxt[3];
  logic [2:0]         entry;
  logic               unused_bits;

  // The three fractional LSBs of each ADT7320 word carry no temperature.
  assign unused_bits = ^{result0[2:0], result1[2:0], result2[2:0]};

  assign temp[0] = result0[15:3];
  assign temp[1] = result1[15:3];
  assign temp[2] = result2[15:3];

  // Exit thresholds are formed one bit wider so a limit near either end
  // of the 13-bit range cannot wrap when hysteresis is applied.
  assign hyst_x  = {10'd0, hyst};
  assign hi_exit = {t_hi[12], t_hi} - hyst_x;
  assign lo_exit = {t_lo[12], t_lo} + hyst_x;

  // A sample arriving on the first edge after reset release is dropped,
  // because the input words may still be settling from the reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign sample_ok = sample & armed;

  // Per-channel next state. dir_lo remembers which limit the NORMAL-state
  // counter is counting toward, so a flip between over and under restarts
  // the count at one instead of carrying the old count across.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      dir_lo_nxt[i] = dir_lo[i];
      entry[i]      = 1'b0;
      temp_x[i]     = {temp[i][12], temp[i]};
      if (sample_ok) begin
        case (state[i])
          NORMAL: begin
            if (temp[i] > t_hi) begin
              cnt_nxt[i]    = dir_lo[i] ? 4'd1 : cnt[i] + 4'd1;
              dir_lo_nxt[i] = 1'b0;
            end else if (temp[i] < t_lo) begin
              cnt_nxt[i]    = dir_lo[i] ? cnt[i] + 4'd1 : 4'd1;
              dir_lo_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = 4'd0;
            end
            if (cnt_nxt[i] == DB) begin
              state_nxt[i] = dir_lo_nxt[i] ? LOW : HIGH;
              cnt_nxt[i]   = 4'd0;
              entry[i]     = 1'b1;
            end
          end
          HIGH: begin
            if (temp_x[i] < hi_exit) cnt_nxt[i] = cnt[i] + 4'd1;
            else                     cnt_nxt[i] = 4'd0;
            if (cnt_nxt[i] == DB) begin
              state_nxt[i] = NORMAL;
              cnt_nxt[i]   = 4'd0;
            end
          end
          LOW: begin
            if (temp_x[i] > lo_exit) cnt_nxt[i] = cnt[i] + 4'd1;
            else                     cnt_nxt[i] = 4'd0;
            if (cnt_nxt[i] == DB) begin
              state_nxt[i] = NORMAL;
              cnt_nxt[i]   = 4'd0;
            end
          end
          default: begin
            state_nxt[i] = NORMAL;
            cnt_nxt[i]   = 4'd0;
          end
        endcase
      end
    end
  end

  // State registers, irq pulse and sticky status. A new alarm entry in the
  // same cycle as clear still sets its status bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state[i]  <= NORMAL;
        cnt[i]    <= 4'd0;
        dir_lo[i] <= 1'b0;
      end
      irq    <= 1'b0;
      status <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state[i]  <= state_nxt[i];
        cnt[i]    <= cnt_nxt[i];
        dir_lo[i] <= dir_lo_nxt[i];
      end
      irq    <= |entry;
      status <= (clear ? 3'b000 : status) | entry;
    end
  end

  always_comb begin
    alarm = 3'b000;
    over  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      alarm[i] = (state[i] != NORMAL);
      over[i]  = (state[i] == HIGH);
    end
  end

`ifdef TEMP_MONITOR_MINMAX_EN
  logic signed [12:0] tmax_r [3];
  logic signed [12:0] tmin_r [3];

  // Running extremes start from the opposite end of the range so the first
  // sample always replaces them; clear with a sample restarts from that
  // sample rather than from the empty values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        tmax_r[i] <= 13'h1000;
        tmin_r[i] <= 13'h0FFF;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sample_ok && clear) begin
          tmax_r[i] <= temp[i];
          tmin_r[i] <= temp[i];
        end else if (sample_ok) begin
          if (temp[i] > tmax_r[i]) tmax_r[i] <= temp[i];
          if (temp[i] < tmin_r[i]) tmin_r[i] <= temp[i];
        end else if (clear) begin
          tmax_r[i] <= 13'h1000;
          tmin_r[i] <= 13'h0FFF;
        end
      end
    end
  end

  assign tmax0 = tmax_r[0];
  assign tmax1 = tmax_r[1];
  assign tmax2 = tmax_r[2];
  assign tmin0 = tmin_r[0];
  assign tmin1 = tmin_r[1];
  assign tmin2 = tmin_r[2];
`endif

endmodule
